// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and data access.
// Optional MEM_TIMEOUT_EN aborts a transfer stuck waiting for mem_ready for MAX_WAIT cycles.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                timeout_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] IF_BUSY = 3'd1;
    localparam logic [2:0] DM_BUSY = 3'd2;
    localparam logic [2:0] IF_DONE = 3'd3;
    localparam logic [2:0] DM_DONE = 3'd4;

    logic [2:0] state_reg;
    logic       abort;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             busy;

    assign busy  = (state_reg == IF_BUSY) || (state_reg == DM_BUSY);
    // The MAX_WAIT-th not-ready BUSY cycle is the last one tolerated.
    assign abort = busy && !mem_ready && (wait_cnt_reg == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (!busy)
                wait_cnt_reg <= '0;
            else if (!mem_ready)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Data wins ties: it belongs to the older instruction.
                    if (dm_req) begin
                        state_reg <= DM_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wstrb <= dm_wstrb;
                    end else if (if_req) begin
                        state_reg <= IF_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wstrb <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ready || abort) begin
                        state_reg <= IF_DONE;
                        mem_req   <= 1'b0;
                        if_valid  <= 1'b1;
                        if_rdata  <= mem_ready ? mem_rdata : '0;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready || abort) begin
                        state_reg <= DM_DONE;
                        mem_req   <= 1'b0;
                        dm_valid  <= 1'b1;
                        if (!mem_we)
                            dm_rdata <= mem_ready ? mem_rdata : '0;
                    end
                end
                // The finishing requester still holds req here, so no grant this cycle.
                IF_DONE, DM_DONE: state_reg <= IDLE;
                default:          state_reg <= IDLE;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule
